// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//
// Purpose:
//   Shares one single-port synchronous RAM between a CPU core (single-word
//   loads/stores) and a secondary burst master (loader/DMA). In IDLE, core
//   accesses pass straight through to the RAM in the same cycle. An accepted
//   burst moves the FSM to BURST. There it issues one beat per cycle at
//   consecutive word addresses, which wrap modulo 2^ADDR_W. The core is
//   stalled until the burst finishes.
//
// Configuration:
//   ARB_ROUND_ROBIN_EN  defined   : on contention the winner alternates; the
//                                   loser of the previous contention wins the
//                                   next one (the core wins the first).
//                       undefined : the core has fixed priority and the
//                                   master can starve.
//
// Ports:
//   CLK, RESET_N         clock (rising edge), asynchronous active-low reset
//   c_read, c_write      core load / store request (both high = store)
//   c_addr, c_wdata      core byte address (bits [ADDR_W+1:2]), store data
//   c_rdata, c_stall     core load data (ram_q), request not serviced
//   m_req, m_we          burst request, burst direction (1 = write)
//   m_addr, m_len        burst start byte address, beats minus one
//   m_wdata              write data for the current beat
//   m_gnt, m_beat        burst accepted pulse, beat issued this cycle
//   m_rvalid, m_rdata    read beat data valid / data
//   m_done               pulse in the cycle after the last beat
//   ram_*                RAM port; ram_q is valid one cycle after ram_wread
// ---------------------------------------------------------------------------
module ram_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              c_read,
    input  logic              c_write,
    input  logic [31:0]       c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_stall,
    input  logic              m_req,
    input  logic              m_we,
    input  logic [31:0]       m_addr,
    input  logic [3:0]        m_len,
    input  logic [DATA_W-1:0] m_wdata,
    output logic              m_gnt,
    output logic              m_beat,
    output logic              m_rvalid,
    output logic [DATA_W-1:0] m_rdata,
    output logic              m_done,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              ram_wread,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_base;
    logic [3:0]        r_len;
    logic [3:0]        r_beat;
    logic              r_we;
    logic              r_rvalid;
    logic              r_done;

    logic              w_core_req;
    logic              w_contend;
    logic              w_master_wins_tie;
    logic              w_last_beat;
    logic [ADDR_W-1:0] w_beat_addr;

    // Only the word-address bits of the byte addresses are used.
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{c_addr[31:ADDR_W+2], c_addr[1:0],
                                  m_addr[31:ADDR_W+2], m_addr[1:0]};

    assign w_core_req  = c_read | c_write;
    assign w_contend   = w_core_req & m_req;
    assign w_last_beat = (r_beat == r_len);
    // Natural ADDR_W-bit overflow provides the modulo-2^ADDR_W wrap.
    assign w_beat_addr = r_base + ADDR_W'(r_beat);

`ifdef ARB_ROUND_ROBIN_EN
    // 1 when the master won the most recent contention.
    logic r_last_master;
    assign w_master_wins_tie = ~r_last_master;
`else
    assign w_master_wins_tie = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        m_gnt        = 1'b0;
        m_beat       = 1'b0;
        c_stall      = 1'b0;
        ram_wren     = 1'b0;
        ram_wread    = 1'b0;
        ram_address  = '0;
        ram_data     = '0;
        unique case (r_state)
            S_IDLE: begin
                if (m_req && (!w_core_req || w_master_wins_tie)) begin
                    // The grant cycle does not access the RAM; the burst starts next cycle.
                    m_gnt        = 1'b1;
                    c_stall      = w_core_req;
                    w_state_next = S_BURST;
                end else if (w_core_req) begin
                    ram_address = c_addr[ADDR_W+1:2];
                    ram_data    = c_wdata;
                    ram_wren    = c_write;
                    ram_wread   = ~c_write;   // a simultaneous read+write is a write
                end
            end
            S_BURST: begin
                m_beat      = 1'b1;
                c_stall     = w_core_req;
                ram_address = w_beat_addr;
                if (r_we) begin
                    ram_data = m_wdata;
                    ram_wren = 1'b1;
                end else begin
                    ram_wread = 1'b1;
                end
                if (w_last_beat) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        // Combinational strobes must be quiet while reset is held, even if
        // requests are present on the inputs.
        if (!RESET_N) begin
            m_gnt     = 1'b0;
            m_beat    = 1'b0;
            c_stall   = 1'b0;
            ram_wren  = 1'b0;
            ram_wread = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state  <= S_IDLE;
            r_base   <= '0;
            r_len    <= '0;
            r_beat   <= '0;
            r_we     <= 1'b0;
            r_rvalid <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_done   <= (r_state == S_BURST) && w_last_beat;
            r_rvalid <= (r_state == S_BURST) && !r_we;
            if (r_state == S_IDLE && m_gnt) begin
                r_base <= m_addr[ADDR_W+1:2];
                r_len  <= m_len;
                r_we   <= m_we;
                r_beat <= '0;
            end else if (r_state == S_BURST) begin
                r_beat <= r_beat + 4'd1;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_last_master <= 1'b1;
        end else if (r_state == S_IDLE && w_contend) begin
            r_last_master <= m_gnt;
        end
    end
`else
    logic w_unused_contend;
    assign w_unused_contend = w_contend;
`endif

    assign m_done   = r_done;
    assign m_rvalid = r_rvalid;
    assign m_rdata  = ram_q;
    assign c_rdata  = ram_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
//
// Drives directed core and burst-master traffic into ram_arbiter, attached to
// a behavioural one-cycle-latency RAM. Every cycle, at the falling edge, the
// DUT outputs are compared against a transaction-level model. The model
// holds a queue of planned beat addresses per burst, a shadow memory and
// one-cycle pending flags. A few literal expectations pin the model itself.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          c_read = 1'b0, c_write = 1'b0;
    logic [31:0]   c_addr = '0;
    logic [DW-1:0] c_wdata = '0;
    logic [DW-1:0] c_rdata;
    logic          c_stall;
    logic          m_req = 1'b0, m_we = 1'b0;
    logic [31:0]   m_addr = '0;
    logic [3:0]    m_len = '0;
    logic [DW-1:0] m_wdata = '0;
    logic          m_gnt, m_beat, m_rvalid, m_done;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] ram_data;
    logic          ram_wren, ram_wread;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_q = '0;

    always #5 CLK = ~CLK;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .c_read(c_read), .c_write(c_write), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_stall(c_stall),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_len(m_len), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_beat(m_beat), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .m_done(m_done),
        .ram_data(ram_data), .ram_wren(ram_wren), .ram_wread(ram_wread),
        .ram_address(ram_address), .ram_q(ram_q)
    );

    // Behavioural RAM with registered read.
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    always @(posedge CLK) begin
        if (ram_wren)  ram_mem[ram_address] <= ram_data;
        if (ram_wread) ram_q <= ram_mem[ram_address];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model state ----------------
    int unsigned     beat_q[$];
    bit              burst_we;
    bit              done_pend, rv_pend, rv_known, crd_pend, crd_known;
    logic [DW-1:0]   rv_exp, crd_exp;
    bit              core_owed = 1'b1;   // core wins the first contention after reset
    logic [DW-1:0]   shadow [int];
    int              beat_log[$];
    int              gnt_cnt = 0, done_cnt = 0, rv_cnt = 0, stall_beat_cnt = 0;

    always @(negedge CLK) begin : compare
        bit core_req, master_wins, e_gnt, e_beat, e_wren, e_wread, e_stall, n_done;
        int unsigned e_addr;
        logic [DW-1:0] e_data;
        if (!RESET_N) begin
            chk("rst_c_stall", c_stall, 0);
            chk("rst_m_gnt", m_gnt, 0);
            chk("rst_m_beat", m_beat, 0);
            chk("rst_m_rvalid", m_rvalid, 0);
            chk("rst_m_done", m_done, 0);
            chk("rst_ram_wren", ram_wren, 0);
            chk("rst_ram_wread", ram_wread, 0);
            beat_q.delete();
            done_pend = 0; rv_pend = 0; crd_pend = 0;
            core_owed = 1'b1;
        end else begin
            core_req = c_read | c_write;
            e_gnt = 0; e_beat = 0; e_wren = 0; e_wread = 0; e_stall = 0; n_done = 0;
            e_addr = 0; e_data = '0;
            if (beat_q.size() > 0) begin
                e_beat  = 1;
                e_addr  = beat_q.pop_front();
                e_stall = core_req;
                if (burst_we) begin e_wren = 1; e_data = m_wdata; end
                else e_wread = 1;
                n_done = (beat_q.size() == 0);
            end else begin
                master_wins = m_req && !core_req;
                if (m_req && core_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                    master_wins = !core_owed;
                    core_owed   = !core_owed;
`endif
                end
                if (master_wins) begin
                    e_gnt    = 1;
                    e_stall  = core_req;
                    burst_we = m_we;
                    for (int i = 0; i <= int'(m_len); i++)
                        beat_q.push_back(((m_addr >> 2) + i) % (1 << AW));
                end else if (core_req) begin
                    e_addr = c_addr[AW+1:2];
                    if (c_write) begin e_wren = 1; e_data = c_wdata; end
                    else e_wread = 1;
                end
            end
            chk("m_gnt", m_gnt, e_gnt);
            chk("m_beat", m_beat, e_beat);
            chk("c_stall", c_stall, e_stall);
            chk("ram_wren", ram_wren, e_wren);
            chk("ram_wread", ram_wread, e_wread);
            chk("m_done", m_done, done_pend);
            chk("m_rvalid", m_rvalid, rv_pend);
            if (rv_pend && rv_known) chk("m_rdata", m_rdata, rv_exp);
            if (crd_pend && crd_known) chk("c_rdata", c_rdata, crd_exp);
            if (e_wren || e_wread) chk("ram_address", ram_address, e_addr);
            if (e_wren) chk("ram_data", ram_data, e_data);
            // observation logs for literal checks
            if (m_beat) beat_log.push_back(int'(ram_address));
            if (m_gnt) gnt_cnt++;
            if (m_done) done_cnt++;
            if (m_rvalid) rv_cnt++;
            if (m_beat && c_stall) stall_beat_cnt++;
            // advance model
            rv_pend  = e_beat && e_wread;
            crd_pend = !e_beat && e_wread;
            rv_known = shadow.exists(int'(e_addr));
            crd_known = rv_known;
            if (rv_known) begin rv_exp = shadow[int'(e_addr)]; crd_exp = rv_exp; end
            if (e_wren) shadow[int'(e_addr)] = e_data;
            done_pend = n_done;
            if (m_gnt || m_done || m_rvalid)
                $display("[TB] t=%0t gnt=%0b done=%0b rvalid=%0b rdata=%0h", $time, m_gnt, m_done, m_rvalid, m_rdata);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge CLK); #1;
    endtask

    task automatic master_burst(input bit we, input logic [31:0] addr, input logic [3:0] len,
                                input logic [31:0] base);
        int nb = 0;
        bit ok = 0;
        m_req = 1; m_we = we; m_addr = addr; m_len = len; m_wdata = base;
        for (int k = 0; k < 8 && !ok; k++) begin #1; if (m_gnt) ok = 1; cyc(); end
        m_req = 0;
        if (!ok) chk("grant_timeout", 0, 1);
        ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            #1;
            if (m_done) ok = 1;
            else begin
                if (m_beat) nb++;
                cyc();
                m_wdata = base + nb;
            end
        end
        if (!ok) chk("done_timeout", 0, 1);
        $display("[TB] burst we=%0b addr=%0h len=%0d beats=%0d", we, addr, len, nb);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int g0, d0, r0, s0;
        bit ok, win_m, exp_m;
        // Reset: requests present must not reach the RAM.
        c_write = 1; c_addr = 32'h10; c_wdata = 32'h1;
        #2;
        chk("lit_rst_wren_gated", ram_wren, 0);
        chk("lit_rst_stall", c_stall, 0);
        c_write = 0;
        repeat (3) cyc();
        RESET_N = 1;
        cyc();

        // Core store then load at 0x10.
        c_write = 1; c_addr = 32'h10; c_wdata = 32'hDEADBEEF;
        #1 chk("lit_cw_addr", ram_address, 4);
        cyc();
        c_write = 0; c_read = 1;
        #1;
        chk("lit_cr_addr", ram_address, 4);
        chk("lit_cr_stall", c_stall, 0);
        chk("lit_cr_wread", ram_wread, 1);
        cyc();
        c_read = 0;
        #1 chk("lit_cr_rdata", c_rdata, 32'hDEADBEEF);
        $display("[TB] core write/read 0x10 rdata=%0h", c_rdata);
        // Read+write together behaves as a write.
        c_read = 1; c_write = 1; c_addr = 32'h20; c_wdata = 32'h1234;
        #1;
        chk("lit_rw_wread", ram_wread, 0);
        chk("lit_rw_wren", ram_wren, 1);
        cyc();
        c_read = 0; c_write = 0;
        cyc();

        // Write burst, 4 beats from address 0.
        beat_log.delete(); g0 = gnt_cnt; d0 = done_cnt;
        master_burst(1, 32'h0, 4'd3, 32'hA000);
        cyc();
        chk("lit_b41_nbeats", beat_log.size(), 4);
        for (int i = 0; i < 4 && i < beat_log.size(); i++)
            chk("lit_b41_addr", beat_log[i], i);
        chk("lit_b41_gnt", gnt_cnt - g0, 1);
        chk("lit_b41_done", done_cnt - d0, 1);

        // Wrapping write then read bursts at word 1022.
        master_burst(1, 32'd1022 * 4, 4'd3, 32'hB000);
        cyc();
        beat_log.delete(); r0 = rv_cnt;
        master_burst(0, 32'd1022 * 4, 4'd3, 32'h0);
        cyc();
        chk("lit_b42_nbeats", beat_log.size(), 4);
        if (beat_log.size() == 4) begin
            chk("lit_b42_a0", beat_log[0], 1022);
            chk("lit_b42_a1", beat_log[1], 1023);
            chk("lit_b42_a2", beat_log[2], 0);
            chk("lit_b42_a3", beat_log[3], 1);
        end
        chk("lit_b42_rvalid", rv_cnt - r0, 4);

        // Core read held during an 8-beat read burst.
        m_req = 1; m_we = 0; m_addr = 32'h100; m_len = 4'd7;
        #1 chk("lit_b43_gnt", m_gnt, 1);
        cyc();
        m_req = 0; c_read = 1; c_addr = 32'h10;
        s0 = stall_beat_cnt; ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            #1;
            if (m_done) begin
                ok = 1;
                chk("lit_b43_served_wread", ram_wread, 1);
                chk("lit_b43_served_stall", c_stall, 0);
            end else cyc();
        end
        if (!ok) chk("b43_done_timeout", 0, 1);
        cyc();
        c_read = 0;
        chk("lit_b43_stall_beats", stall_beat_cnt - s0, 8);
        $display("[TB] core read stalled %0d beats", stall_beat_cnt - s0);
        cyc();

        // Reset during beat 2 of a 4-beat write burst.
        m_req = 1; m_we = 1; m_addr = 32'h40; m_len = 4'd3; m_wdata = 32'hC000;
        #1 chk("lit_b45_gnt", m_gnt, 1);
        cyc();
        m_req = 0;
        cyc();
        #1 chk("lit_b45_beat2", m_beat, 1);
        RESET_N = 0;
        #1;
        chk("lit_b45_beat0", m_beat, 0);
        chk("lit_b45_wren0", ram_wren, 0);
        chk("lit_b45_done0", m_done, 0);
        d0 = done_cnt;
        repeat (2) cyc();
        RESET_N = 1;
        repeat (4) cyc();
        chk("lit_b45_no_done", done_cnt - d0, 0);
        c_write = 1; c_addr = 32'h40; c_wdata = 32'h55;
        #1;
        chk("lit_b45_idle_wren", ram_wren, 1);
        chk("lit_b45_idle_addr", ram_address, 16);
        cyc();
        c_write = 0;
        cyc();

        // Repeated contention.
        for (int r = 0; r < 4; r++) begin
            c_read = 1; c_addr = 32'h300;
            m_req = 1; m_we = 0; m_addr = 32'h80; m_len = 4'd0;
            #1;
            win_m = m_gnt;
`ifdef ARB_ROUND_ROBIN_EN
            exp_m = (r % 2 == 1);
`else
            exp_m = 0;
`endif
            chk("lit_b44_winner", win_m, exp_m);
            chk("lit_b44_loser_stall", c_stall, exp_m);
            $display("[TB] contention %0d winner=%s", r, win_m ? "master" : "core");
            cyc();
            c_read = 0; m_req = 0;
            repeat (4) cyc();
        end

        repeat (2) cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
